// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory access stage.
// ALU results pass straight to writeback after one cycle. Loads and stores
// issue a single word request on the dmem port and hold execute off until
// the memory acks or the request times out.
module mem_access_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [3:0]        ex_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [3:0]        wb_dest,
  output logic [31:0]       wb_data,
  output logic [3:0]        mem_busy_dest,
  output logic              err_align,
  output logic              err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, MEM} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          dest_q, dest_d;
  logic                ldwb_q, ldwb_d;     // pending access is a load that writes back
  logic [TW-1:0]       timer_q, timer_d;
  logic                wb_valid_q, wb_valid_d;
  logic [3:0]          wb_dest_q, wb_dest_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                err_align_q, err_align_d;
  logic                err_to_q, err_to_d;

  logic mem_op, bad_op;

  assign mem_op = ex_mem_read | ex_mem_write;
  assign bad_op = (ex_result[1:0] != 2'b00) | (ex_mem_read & ex_mem_write);

  // Next-state: accept from execute in IDLE, track the outstanding access in MEM
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dest_d      = dest_q;
    ldwb_d      = ldwb_q;
    timer_d     = timer_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = 4'd0;
    wb_data_d   = 32'd0;
    err_align_d = 1'b0;
    err_to_d    = err_to_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!mem_op) begin
            wb_valid_d = ex_reg_write;
            wb_dest_d  = ex_dest;
            wb_data_d  = ex_result;
          end else if (bad_op) begin
            err_align_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = ex_result[ADDR_W+1:2];
            wdata_d = ex_store_data;
            dest_d  = ex_dest;
            ldwb_d  = ex_reg_write & ~ex_mem_write;
            timer_d = '0;
            state_d = MEM;
          end
        end
      end
      MEM: begin
        // req is always high here, so ack is only honoured while requesting;
        // an ack on the final timeout cycle still completes normally
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (ldwb_q) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_q;
            wb_data_d  = dmem_rdata;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          req_d    = 1'b0;
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset drops the memory request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      dest_q      <= 4'd0;
      ldwb_q      <= 1'b0;
      timer_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 4'd0;
      wb_data_q   <= 32'd0;
      err_align_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dest_q      <= dest_d;
      ldwb_q      <= ldwb_d;
      timer_q     <= timer_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      err_align_q <= err_align_d;
      err_to_q    <= err_to_d;
    end
  end

  assign ex_ready      = (state_q == IDLE);
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_dest       = wb_dest_q;
  assign wb_data       = wb_data_q;
  assign mem_busy_dest = dest_q;
  assign err_align     = err_align_q;
  assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized transaction-level check of mem_access_stage: each instruction's
// expected writeback/request/error behaviour is derived from its fields.
module tb_mem_access_stage;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic [31:0]       ex_result = '0;
  logic [31:0]       ex_store_data = '0;
  logic [3:0]        ex_dest = '0;
  logic              ex_mem_read = 1'b0;
  logic              ex_mem_write = 1'b0;
  logic              ex_reg_write = 1'b0;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack = 1'b0;
  logic [31:0]       dmem_rdata = '0;
  logic              wb_valid;
  logic [3:0]        wb_dest;
  logic [31:0]       wb_data;
  logic [3:0]        mem_busy_dest;
  logic              err_align;
  logic              err_timeout;

  int nvec = 0;
  int nerr = 0;
  logic exp_to = 1'b0;

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .mem_busy_dest(mem_busy_dest), .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ALU op presented at a negedge; result checked at the following negedge.
  // dmem_ack is toggled randomly meanwhile: it must be ignored with no request.
  task automatic alu(input logic [3:0] d, input logic [31:0] v, input logic rw);
    ex_valid = 1'b1; ex_result = v; ex_store_data = $urandom; ex_dest = d;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = rw;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    chk("alu_ready", ex_ready, 1);
    @(negedge clk);
    ex_valid = 1'b0; dmem_ack = 1'b0;
    chk("alu_wbv", wb_valid, rw);
    if (rw) begin
      chk("alu_wbdest", wb_dest, d);
      chk("alu_wbdata", wb_data, v);
    end
    chk("alu_noreq", dmem_req, 0);
    chk("alu_noalign", err_align, 0);
    chk("alu_errto", err_timeout, exp_to);
  endtask

  // Memory op; dly = cycles of req before ack (>= TIMEOUT means never).
  task automatic mem(input logic [31:0] a, input logic re, input logic we,
                     input logic [31:0] sd, input logic [3:0] d, input logic rw,
                     input int dly, input logic [31:0] rd);
    logic bad;
    logic done;
    logic [ADDR_W-1:0] wa;
    bad = (a[1:0] != 2'b00) || (re && we);
    wa  = a[ADDR_W+1:2];
    ex_valid = 1'b1; ex_result = a; ex_store_data = sd; ex_dest = d;
    ex_mem_read = re; ex_mem_write = we; ex_reg_write = rw; dmem_ack = 1'b0;
    chk("mem_ready", ex_ready, 1);
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    if (bad) begin
      chk("bad_align", err_align, 1);
      chk("bad_noreq", dmem_req, 0);
      chk("bad_nowb", wb_valid, 0);
      chk("bad_ready", ex_ready, 1);
      return;
    end
    chk("mem_noalign", err_align, 0);
    done = 1'b0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      chk("req_hi", dmem_req, 1);
      chk("req_we", dmem_we, we);
      chk("req_addr", dmem_addr, wa);
      chk("req_wdata", dmem_wdata, sd);
      chk("req_busy", ex_ready, 0);
      chk("req_nowb", wb_valid, 0);
      if (re) chk("busy_dest", mem_busy_dest, d);
      if (k == dly) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("ack_reqlo", dmem_req, 0);
        chk("ack_ready", ex_ready, 1);
        chk("ack_wbv", wb_valid, re & rw);
        if (re & rw) begin
          chk("ack_wbdest", wb_dest, d);
          chk("ack_wbdata", wb_data, rd);
        end
        chk("ack_errto", err_timeout, exp_to);
        done = 1'b1;
      end else if (k == TIMEOUT - 1) begin
        @(negedge clk);
        exp_to = 1'b1;
        chk("to_reqlo", dmem_req, 0);
        chk("to_err", err_timeout, 1);
        chk("to_nowb", wb_valid, 0);
        chk("to_ready", ex_ready, 1);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("mem_done", done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, ex_ready, 1);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbdest"}, wb_dest, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_busy"}, mem_busy_dest, 0);
    chk({tag, "_align"}, err_align, 0);
    chk({tag, "_errto"}, err_timeout, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    alu(4'd3, 32'h0000_1234, 1'b1);
    for (int i = 0; i < 4; i++) alu(4'(i + 5), 32'h100 + 32'(i), 1'b1);
    alu(4'd9, 32'h5555_AAAA, 1'b0);
    mem(32'h0000_0010, 1'b1, 1'b0, 32'h0, 4'd7, 1'b1, 0, 32'hDEAD_BEEF);
    mem(32'h0000_0008, 1'b0, 1'b1, 32'hCAFE_F00D, 4'd2, 1'b0, 3, 32'h0);
    mem(32'h0000_0006, 1'b1, 1'b0, 32'h0, 4'd4, 1'b1, 0, 32'h0);
    mem(32'h0000_0020, 1'b1, 1'b1, 32'h0, 4'd4, 1'b1, 0, 32'h0);
    mem(32'h0000_0040, 1'b1, 1'b0, 32'h0, 4'd6, 1'b1, TIMEOUT - 1, 32'h1357_9BDF);
    mem(32'h0000_0FFC, 1'b1, 1'b0, 32'h0, 4'd8, 1'b1, 1000, 32'h0);
    alu(4'd1, 32'hA5A5_0001, 1'b1);
    mem(32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'd11, 1'b1, 2, 32'h2468_ACE0);

    // randomized instruction mix
    for (int n = 0; n < 250; n++) begin
      int kind;
      int r;
      int dly;
      logic [31:0] a;
      kind = $urandom_range(0, 10);
      r = $urandom_range(0, 9);
      dly = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TIMEOUT - 1 :
            (r == 8) ? TIMEOUT + 3 : $urandom_range(4, 12);
      a = {20'($urandom), 10'($urandom), 2'b00};
      if (kind <= 4)
        alu(4'($urandom), $urandom, 1'($urandom_range(0, 1)));
      else if (kind <= 7)
        mem(a, 1'b1, 1'b0, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), dly, $urandom);
      else if (kind <= 9)
        mem(a, 1'b0, 1'b1, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), dly, $urandom);
      else if (r < 5)
        mem(a | 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1, $urandom,
            4'($urandom), 1'b1, 0, $urandom);
      else
        mem(a, 1'b1, 1'b1, $urandom, 4'($urandom), 1'b1, 0, $urandom);
    end

    // reset in the middle of an outstanding load
    ex_valid = 1'b1; ex_result = 32'h0000_0044; ex_store_data = 32'h0; ex_dest = 4'd12;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("mrst_req_before", dmem_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req_async", dmem_req, 0);
    chk("mrst_ready_async", ex_ready, 1);
    exp_to = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("mrst");
    @(negedge clk);
    alu(4'd13, 32'h0BAD_F00D, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // hard bound on run length
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
